// File: rtl/tia_pkg.sv
// Shared phase encoding for the TIA two-phase strobe sequencer.
package tia_pkg;

  typedef enum logic [1:0] {
    P_S1 = 2'd0,
    P_GA = 2'd1,
    P_S2 = 2'd2,
    P_GB = 2'd3
  } phase_t;

endpackage

// File: rtl/tia_phase_timer.sv
// Duration counter: counts up from 0, flags the last cycle of a state,
// and can be cleared on a state change or frozen while parked.
module tia_phase_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          hold_i,
  input  logic [CW-1:0] lim_i,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i)       cnt_d = '0;
    else if (hold_i) cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == lim_i);

endmodule

// File: rtl/tia_phase_ctl.sv
// Two-phase non-overlapping s1/s2 strobe sequencer with run, single-step
// and resync control for the TIA D1/D2 shift-stage chains.
module tia_phase_ctl
  import tia_pkg::*;
#(
  parameter int S1_W  = 1,
  parameter int GAP_W = 1,
  parameter int S2_W  = 1,
  parameter int CW    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic       resync,
  output logic       s1,
  output logic       s2,
  output logic [1:0] phase,
  output logic       busy,
  output logic       cycle_done
);

  if (S1_W < 1 || GAP_W < 1 || S2_W < 1) begin : g_bad_width
    $error("tia_phase_ctl: all phase widths must be >= 1");
  end
  if (S1_W > 2**CW || GAP_W > 2**CW || S2_W > 2**CW) begin : g_bad_cw
    $error("tia_phase_ctl: CW too narrow for the phase widths");
  end

  localparam logic [CW-1:0] S1_LIM  = CW'(S1_W - 1);
  localparam logic [CW-1:0] GAP_LIM = CW'(GAP_W - 1);
  localparam logic [CW-1:0] S2_LIM  = CW'(S2_W - 1);

  phase_t        state_q, state_d;
  logic          parked_q, parked_d;
  logic          s1_q, s2_q, done_q, done_d;
  logic          clr, hold, tc;
  logic [CW-1:0] lim;

  always_comb begin
    unique case (state_q)
      P_S1:    lim = S1_LIM;
      P_S2:    lim = S2_LIM;
      default: lim = GAP_LIM;
    endcase
  end

  tia_phase_timer #(.CW(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (clr),
    .hold_i(hold),
    .lim_i (lim),
    .tc_o  (tc)
  );

  // Resync and an accepted step act on the very next edge; everything else
  // waits for the current state's width to expire.
  always_comb begin
    state_d  = state_q;
    parked_d = parked_q;
    done_d   = 1'b0;
    clr      = 1'b0;
    hold     = 1'b0;
    if (resync) begin
      state_d  = P_GB;
      parked_d = 1'b0;
      clr      = 1'b1;
    end else if (parked_q && !run && step) begin
      state_d  = P_S1;
      parked_d = 1'b0;
      clr      = 1'b1;
    end else if (tc) begin
      unique case (state_q)
        P_S1: begin state_d = P_GA; clr = 1'b1; end
        P_GA: begin state_d = P_S2; clr = 1'b1; end
        P_S2: begin state_d = P_GB; clr = 1'b1; done_d = 1'b1; end
        P_GB: begin
          if (run) begin
            state_d  = P_S1;
            parked_d = 1'b0;
            clr      = 1'b1;
          end else begin
            parked_d = 1'b1;
            hold     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= P_GB;
      parked_q <= 1'b1;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      parked_q <= parked_d;
      s1_q     <= (state_d == P_S1);
      s2_q     <= (state_d == P_S2);
      done_q   <= done_d;
    end
  end

  assign s1         = s1_q;
  assign s2         = s2_q;
  assign phase      = state_q;
  assign busy       = ~parked_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_tia_phase_ctl.sv
// Randomized check of three sequencer width configurations against a
// position-in-cycle reference model, plus a directed default-width segment.
module tb_tia_phase_ctl;

  logic clk = 1'b0;
  logic reset, run, step, resync;
  logic [2:0]      s1, s2, busy, done;
  logic [2:0][1:0] phase;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tia_phase_ctl #(.S1_W(1), .GAP_W(1), .S2_W(1), .CW(4)) u_dut0 (
    .clk(clk), .reset(reset), .run(run), .step(step), .resync(resync),
    .s1(s1[0]), .s2(s2[0]), .phase(phase[0]), .busy(busy[0]), .cycle_done(done[0]));

  tia_phase_ctl #(.S1_W(2), .GAP_W(1), .S2_W(3), .CW(4)) u_dut1 (
    .clk(clk), .reset(reset), .run(run), .step(step), .resync(resync),
    .s1(s1[1]), .s2(s2[1]), .phase(phase[1]), .busy(busy[1]), .cycle_done(done[1]));

  tia_phase_ctl #(.S1_W(1), .GAP_W(3), .S2_W(2), .CW(4)) u_dut2 (
    .clk(clk), .reset(reset), .run(run), .step(step), .resync(resync),
    .s1(s1[2]), .s2(s2[2]), .phase(phase[2]), .busy(busy[2]), .cycle_done(done[2]));

  // Reference: each instance is a position within one full phase cycle
  // (0 = first S1 cycle), a parked flag and a cycle-done flag.
  int w1[3] = '{1, 2, 1};
  int wg[3] = '{1, 1, 3};
  int w2[3] = '{1, 3, 2};
  int pos[3];
  bit parked[3];
  bit mdone[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_vec(int i);
    int a, b, c;
    logic [1:0] ph;
    a = w1[i];
    b = a + wg[i];
    c = b + w2[i];
    if (pos[i] < a)      ph = 2'd0;
    else if (pos[i] < b) ph = 2'd1;
    else if (pos[i] < c) ph = 2'd2;
    else                 ph = 2'd3;
    return {pos[i] < a, pos[i] >= b && pos[i] < c, ph, ~parked[i], mdone[i]};
  endfunction

  function automatic logic [5:0] obs_vec(int i);
    return {s1[i], s2[i], phase[i], busy[i], done[i]};
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int per, gb;
      per = w1[i] + wg[i] + w2[i] + wg[i];
      gb  = per - wg[i];
      if (reset) begin
        pos[i] = gb; parked[i] = 1'b1; mdone[i] = 1'b0;
      end else if (resync) begin
        pos[i] = gb; parked[i] = 1'b0; mdone[i] = 1'b0;
      end else if (parked[i] && !run && step) begin
        pos[i] = 0; parked[i] = 1'b0; mdone[i] = 1'b0;
      end else if (pos[i] == per - 1) begin
        mdone[i] = 1'b0;
        if (run) begin pos[i] = 0; parked[i] = 1'b0; end
        else parked[i] = 1'b1;
      end else begin
        pos[i]++;
        mdone[i] = (pos[i] == gb);
      end
    end
  endtask

  // One clock: edge uses the currently driven inputs; compare at negedge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model[%0d]", i), 32'(obs_vec(i)), 32'(exp_vec(i)));
      chk($sformatf("nonovl[%0d]", i), 32'(s1[i] & s2[i]), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; step = 1'b0; resync = 1'b0;
    @(negedge clk);
    tick();
    chk("rst_vals", 32'(obs_vec(0)), 32'h0c);
    reset = 1'b0;
    // Directed free-run at default widths: s1 at 1,5,9; s2 at 3,7; done at 4,8.
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk($sformatf("dir_s1 c%0d", c), 32'(s1[0]), 32'((c % 4) == 1));
      chk($sformatf("dir_s2 c%0d", c), 32'(s2[0]), 32'((c % 4) == 3));
      chk($sformatf("dir_done c%0d", c), 32'(done[0]), 32'((c % 4) == 0));
    end
    // Reset during S1 with resync and step also high.
    reset = 1'b1; resync = 1'b1; step = 1'b1;
    tick();
    chk("rst_over_all", 32'(obs_vec(0)), 32'h0c);
    reset = 1'b0; resync = 1'b0; step = 1'b0; run = 1'b0;
    // Directed single step at default widths.
    for (int c = 0; c < 4; c++) tick();
    step = 1'b1;
    tick();
    chk("step_s1", 32'(s1[0]), 32'd1);
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    chk("step_s2", 32'(s2[0]), 32'd1);
    step = 1'b0;
    tick();
    chk("step_done", 32'(done[0]), 32'd1);
    tick();
    chk("step_parked", 32'({busy[0], phase[0]}), 32'h3);
    // Randomized run/step/resync/reset mix.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      step   = ($urandom_range(0, 5) == 0);
      resync = ($urandom_range(0, 24) == 0);
      reset  = ($urandom_range(0, 199) == 0);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
